// File: rtl/uncache_axi_bridge.sv
// ---------------------------------------------------------------------------
// uncache_axi_bridge
//
// Purpose:
//   Converts the SRAM-like data port of the uncached write buffer into
//   single-beat AXI3 transactions. Only one transaction is in flight at a
//   time, so reads and buffered writes reach the interconnect in program
//   order, which MMIO accesses depend on.
//
// Optional feature (macro UNCACHE_BRIDGE_EARLY_WACK_EN):
//   When defined, a write is acknowledged (s_data_ok) as soon as both AW and
//   W have handshaken. The B response is then absorbed in the background
//   while a pending flag blocks new requests. bresp is not reported on
//   s_err in this mode. When undefined, writes complete only after B and
//   s_err reflects bresp.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_req/s_wr/s_size/s_addr  SRAM-like request (size 0=byte,1=half,2=word)
//   s_wdata/s_wstrb           write data and byte enables
//   s_addr_ok                 request accepted this cycle (combinational)
//   s_data_ok/s_rdata/s_err   completion pulse, read data, error pulse
//   ar*/r*                    AXI3 read address / read data channels
//   aw*/w*/b*                 AXI3 write address / write data / response
// ---------------------------------------------------------------------------
module uncache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s_req,
    input  logic              s_wr,
    input  logic [1:0]        s_size,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic [31:0]       s_rdata,
    output logic              s_addr_ok,
    output logic              s_data_ok,
    output logic              s_err,

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,

    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,

    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW_W,
        WR_B,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              accept_window;

    // Response IDs and rlast carry no information for single-beat,
    // single-outstanding traffic, so they are deliberately not looked at.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rlast, bid};

`ifdef UNCACHE_BRIDGE_EARLY_WACK_EN
    // Set while an early-acknowledged write still owes its B response.
    logic b_pending;
    assign accept_window = (state == IDLE || state == DONE) && !b_pending;
`else
    assign accept_window = (state == IDLE || state == DONE);
`endif

    assign s_addr_ok = s_req && accept_window;

    // All AXI request fields come straight from the latched request, so they
    // stay stable for as long as the corresponding valid is held.
    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;

    assign wid     = AXI_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    // Transaction sequencer. Every handshake output is registered and is
    // raised on the transition into the state that owns it, which gives the
    // accept -> valid -> response -> data_ok cadence of one cycle per step.
    // In WR_AW_W a channel counts as finished once its valid has dropped, so
    // AW and W may complete together or in either order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            size_q    <= 2'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            s_data_ok <= 1'b0;
            s_err     <= 1'b0;
            s_rdata   <= 32'd0;
`ifdef UNCACHE_BRIDGE_EARLY_WACK_EN
            b_pending <= 1'b0;
`endif
        end else begin
            s_data_ok <= 1'b0;
            s_err     <= 1'b0;

`ifdef UNCACHE_BRIDGE_EARLY_WACK_EN
            if (b_pending && bvalid) begin
                b_pending <= 1'b0;
                bready    <= 1'b0;
            end
`endif

            case (state)
                IDLE, DONE: begin
                    if (s_addr_ok) begin
                        addr_q  <= s_addr;
                        size_q  <= s_size;
                        wdata_q <= s_wdata;
                        wstrb_q <= s_wstrb;
                        if (s_wr) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_AW_W;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_AR;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                RD_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_R;
                    end
                end

                RD_R: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        s_rdata   <= rdata;
                        s_err     <= (rresp != 2'b00);
                        s_data_ok <= 1'b1;
                        state     <= DONE;
                    end
                end

                WR_AW_W: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
`ifdef UNCACHE_BRIDGE_EARLY_WACK_EN
                        b_pending <= 1'b1;
                        s_data_ok <= 1'b1;
                        state     <= IDLE;
`else
                        state     <= WR_B;
`endif
                    end
                end

                WR_B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        s_err     <= (bresp != 2'b00);
                        s_data_ok <= 1'b1;
                        state     <= DONE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
